branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-cycle branch comparator.
- Takes a decoded conditional branch (rs1, rs2, funct3, pc, imm) over a valid/ready handshake.
- Evaluates all six RV32/RV64 branch conditions in signed or unsigned mode, computes the target and next PC, and flags misaligned targets and illegal funct3.
- Result is registered (1-cycle latency) for the execute→PC-select path; saturating branch/taken counters are kept for performance monitoring.

Parameters:
- XLEN, 32, operand/PC width (32 or 64).
- CNT_W, 32, width of each performance counter.
- IALIGN, 32, instruction alignment in bits (32 → target[1:0] must be 0; 16 → only target[0] must be 0).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request
- in_rs1  in  XLEN  operand 1
- in_rs2  in  XLEN  operand 2
- in_funct3  in  3  branch type (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU)
- in_pc  in  XLEN  branch instruction PC
- in_imm  in  XLEN  sign-extended B-immediate
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_taken  out  1  condition true
- out_next_pc  out  XLEN  taken ? pc+imm : pc+4
- out_misaligned  out  1  taken and target violates IALIGN
- out_illegal  out  1  funct3 is 010 or 011
- cnt_clear  in  1  synchronous clear of both counters
- cnt_branches  out  CNT_W  legal branches retired
- cnt_taken  out  CNT_W  taken branches retired

Behaviour:
- Reset: out_valid=0, out_taken=0, out_next_pc=0, out_misaligned=0, out_illegal=0, cnt_branches=0, cnt_taken=0. in_ready=1 the cycle after reset deasserts.
- Reset asserted mid-operation discards any held result with no counter update.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Input fire = in_valid && in_ready; output fire = out_valid && out_ready.
  - On input fire, result registers load and out_valid=1 next cycle (latency 1).
  - If output fires without an input fire, out_valid→0.
  - Simultaneous input and output fire: out_valid stays 1 and new data loads (full throughput, one result per cycle).
  - While out_valid && !out_ready, all out_* hold stable and the input is stalled.
- Conditions:
  - eq = rs1==rs2.
  - lt = signed compare for funct3 10x, unsigned compare for 11x.
  - BEQ: eq. BNE: !eq. BLT/BLTU: lt. BGE/BGEU: !lt.
  - funct3[1] selects unsigned; funct3[0] inverts the base result.
- Illegal funct3 (010, 011): out_illegal=1, out_taken=0, out_next_pc=pc+4, out_misaligned=0.
- Arithmetic:
  - target = pc+imm, truncated to XLEN (wrap-around, no overflow flag).
  - fallthrough = pc+4, wraps likewise.
- Misalignment:
  - out_misaligned = taken && (IALIGN==32 ? target[1:0]!=0 : target[0]).
  - out_next_pc still reports the target; the trap decision is made downstream.
- Counters (update on output fire):
  - cnt_branches += 1 if !illegal.
  - cnt_taken += 1 if taken.
  - Both saturate at all-ones and never wrap.
  - cnt_clear has priority over a same-cycle increment (result 0).
  - Counters are readable at all times.
- out_illegal, out_taken and out_misaligned may be asserted only together with out_valid.

Decomposition:
- Shared package (branch_pkg):
  - branch_funct3_e enum for the six legal codes.
  - Localparams for the fallthrough increment (4) and IALIGN values.
- One natural sub-module: branch_cond_eval. Purely combinational: (rs1, rs2, funct3) → taken, illegal. Reusable by a future predictor checker.
- Handshake register and counters stay in the top level.

Test Plan:
1. BLT signed: rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 → one cycle later out_valid=1, taken=1, next_pc=0x120. Repeat as BLTU → taken=0, next_pc=0x104.
2. BEQ/BNE: rs1=rs2=0x55 → BEQ taken with next_pc=pc+imm; BNE not taken with next_pc=pc+4. funct3=010 → illegal=1, taken=0, cnt_branches unchanged.
3. Backpressure: out_ready=0 for 3 cycles with in_valid held high → in_ready=0, outputs stable. Then out_ready=1 with back-to-back inputs → one result per cycle, no loss or duplication, counters match the accepted count.
4. Wrap/misalign: pc=0xFFFFFFFC, imm=8, BEQ taken → next_pc=0x00000004. pc=0x100, imm=0x6 taken → misaligned=1 (IALIGN=32), misaligned=0 (IALIGN=16).
5. Counters: CNT_W=4, retire 20 taken BGE → both counters at 0xF. cnt_clear asserted in the same cycle as a fire → both counters 0.
6. Reset mid-operation: assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0, counters 0; the first post-reset request completes normally.

Source files
------------

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pkg
//  Purpose  : Shared types and constants for the branch resolution logic.
//             Provides the legal conditional-branch funct3 encodings, the
//             fall-through PC increment and the supported IALIGN values.
//  Ports    : (package - none)
//  Revision : 1.0 - initial release
// ============================================================================
package branch_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_funct3_e;

    // Fall-through advance for a 32-bit branch instruction.
    localparam int FALLTHROUGH_INC = 4;

    // Supported instruction alignments, in bits.
    localparam int IALIGN_32 = 32;
    localparam int IALIGN_16 = 16;

endpackage : branch_pkg
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module   : branch_cond_eval
//  Purpose  : Purely combinational evaluation of a conditional branch.
//             funct3[2] = 0 selects the equality compare, 1 the less-than
//             compare; funct3[1] picks unsigned less-than; funct3[0] inverts
//             the base result. Codes 010/011 are reported illegal and never
//             taken.
//  Ports    : rs1_i, rs2_i  - operands (XLEN)
//             funct3_i      - branch type (3)
//             taken_o       - branch condition true (legal codes only)
//             illegal_o     - funct3 is 010 or 011
//  Revision : 1.0 - initial release
// ============================================================================
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [2:0]      funct3_i,
    output logic            taken_o,
    output logic            illegal_o
);

    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;
    logic w_base;

    always_comb begin
        w_eq      = (rs1_i == rs2_i);
        w_lt_s    = ($signed(rs1_i) < $signed(rs2_i));
        w_lt_u    = (rs1_i < rs2_i);
        illegal_o = (funct3_i[2:1] == 2'b01);
        if (funct3_i[2]) begin
            w_base = funct3_i[1] ? w_lt_u : w_lt_s;
        end else begin
            w_base = w_eq;
        end
        taken_o = !illegal_o && (w_base ^ funct3_i[0]);
    end

endmodule : branch_cond_eval
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_unit
//  Purpose  : Resolves a decoded conditional branch over a valid/ready
//             handshake with a single registered output stage (latency 1,
//             full throughput). Computes taken, next PC, misalignment and
//             illegal-funct3 flags, and keeps saturating retire counters.
//  Ports    : clk, rst                 - clock, sync active-high reset
//             in_valid/in_ready        - request handshake
//             in_rs1, in_rs2, in_funct3, in_pc, in_imm - request payload
//             out_valid/out_ready      - result handshake
//             out_taken, out_next_pc, out_misaligned, out_illegal - result
//             cnt_clear                - synchronous counter clear
//             cnt_branches, cnt_taken  - legal / taken branches retired
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CNT_W  = 32,
    parameter int IALIGN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_next_pc,
    output logic             out_misaligned,
    output logic             out_illegal,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_taken
);

    logic w_taken;
    logic w_illegal;

    branch_cond_eval #(
        .XLEN (XLEN)
    ) u_cond (
        .rs1_i     (in_rs1),
        .rs2_i     (in_rs2),
        .funct3_i  (in_funct3),
        .taken_o   (w_taken),
        .illegal_o (w_illegal)
    );

    logic            valid_q;
    logic            taken_q;
    logic            misaligned_q;
    logic            illegal_q;
    logic [XLEN-1:0] next_pc_q;
    logic [CNT_W-1:0] cnt_br_q;
    logic [CNT_W-1:0] cnt_tk_q;

    logic            w_in_fire;
    logic            w_out_fire;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_fallthru;
    logic [XLEN-1:0] next_pc_d;
    logic            misaligned_d;

    always_comb begin
        in_ready   = !valid_q || out_ready;
        w_in_fire  = in_valid && in_ready;
        w_out_fire = valid_q && out_ready;
        // Both sums wrap at XLEN; no overflow is reported.
        w_target   = in_pc + in_imm;
        w_fallthru = in_pc + XLEN'(FALLTHROUGH_INC);
        next_pc_d  = w_taken ? w_target : w_fallthru;
        if (IALIGN == IALIGN_32) begin
            misaligned_d = w_taken && (w_target[1:0] != 2'b00);
        end else begin
            misaligned_d = w_taken && w_target[0];
        end
    end

    // Result stage. Flags are dropped when the result drains so they are
    // never seen asserted without out_valid; next_pc simply holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            next_pc_q    <= '0;
        end else if (w_in_fire) begin
            valid_q      <= 1'b1;
            taken_q      <= w_taken;
            misaligned_q <= misaligned_d;
            illegal_q    <= w_illegal;
            next_pc_q    <= next_pc_d;
        end else if (w_out_fire) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
        end
    end

    // Retire counters: count on output fire, saturate at all-ones,
    // clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cnt_br_q <= '0;
            cnt_tk_q <= '0;
        end else if (w_out_fire) begin
            if (!illegal_q && (cnt_br_q != '1)) begin
                cnt_br_q <= cnt_br_q + CNT_W'(1);
            end
            if (taken_q && (cnt_tk_q != '1)) begin
                cnt_tk_q <= cnt_tk_q + CNT_W'(1);
            end
        end
    end

    assign out_valid      = valid_q;
    assign out_taken      = taken_q;
    assign out_next_pc    = next_pc_q;
    assign out_misaligned = misaligned_q;
    assign out_illegal    = illegal_q;
    assign cnt_branches   = cnt_br_q;
    assign cnt_taken      = cnt_tk_q;

endmodule : branch_resolve_unit
`default_nettype wire
